// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clk_gen_pkg;

  localparam int unsigned ACC_W_MAX  = 32;
  localparam int unsigned NUM_CH_MAX = 16;

  // Rounded increment for a requested output frequency: inc = f_out * 2^acc_w / f_clk.
  function automatic logic [ACC_W_MAX-1:0] inc_for(input longint unsigned f_clk_hz,
                                                   input longint unsigned f_out_hz,
                                                   input int unsigned     acc_w);
    longint unsigned scaled;
    scaled = ((f_out_hz << acc_w) + (f_clk_hz >> 1)) / f_clk_hz;
    return scaled[ACC_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/clk_ce_chan.sv
// One phase-accumulator channel: increment register, accumulator, ce and square-wave flops.
module clk_ce_chan
  import clk_gen_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [ACC_W-1:0] inc_init,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic             clear,
  output logic             ce,
  output logic             clk_out
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // Accumulator step with carry out.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, inc};
  end

  // Increment/accumulator state; load or clear restarts the phase from zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc     <= '0;
      inc     <= inc_init;
      ce      <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (load) begin
        inc <= load_inc;
      end
      if (load || clear) begin
        acc     <= '0;
        ce      <= 1'b0;
        clk_out <= 1'b0;
      end else begin
        acc     <= sum[ACC_W-1:0];
        ce      <= sum[ACC_W];
        clk_out <= sum[ACC_W-1];
      end
    end
  end

endmodule

// File: rtl/clk_ce_gen.sv
// Multi-channel clock-enable generator with lock detection and downstream reset sequencing.
module clk_ce_gen
  import clk_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 4,
  parameter int                      ACC_W       = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = {NUM_CH{16'h1000}},
  parameter int                      LOCK_CYCLES = 256,
  parameter int                      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_sync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked,
  output logic              rst_out_n
);

  localparam int              CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] load;
  logic              cfg_valid;
  logic              lock_clear;
  logic [CNT_W-1:0]  lock_cnt;

  // Config decode: out-of-range channel writes are dropped and do not disturb lock.
  always_comb begin
    load       = '0;
    cfg_valid  = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    lock_clear = cfg_valid || cfg_sync;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_ce_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .inc_init (INC_DEFAULT[i*ACC_W +: ACC_W]),
      .load     (load[i]),
      .load_inc (cfg_inc),
      .clear    (cfg_sync),
      .ce       (ce[i]),
      .clk_out  (clk_out[i])
    );
  end

  // Lock counter and reset sequencer; a config event always wins over the terminal count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_cnt  <= '0;
      locked    <= 1'b0;
      rst_out_n <= 1'b0;
    end else begin
      rst_out_n <= locked;
      if (lock_clear) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (lock_cnt == LOCK_TERM) begin
        locked <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_ce_gen.sv
// Directed self-checking bench for clk_ce_gen (2-channel main instance, 3-channel instance for invalid index).
module tb_clk_ce_gen;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_ch = 1'b0;
  logic [7:0] cfg_inc = '0;
  logic       cfg_sync = 1'b0;
  logic [1:0] ce, clk_out;
  logic       locked, rst_out_n;

  logic       cfg3_we = 1'b0;
  logic [1:0] cfg3_ch = '0;
  logic [7:0] cfg3_inc = '0;
  logic       cfg3_sync = 1'b0;
  logic [2:0] ce3, clk_out3;
  logic       locked3, rst_out_n3;

  int total = 0;
  int bad = 0;

  // Expectation state: t = edges since reset release, p0/p1 = edges since channel clear,
  // lk = edges since last lock clear, P0/P1 = wrap periods (0 = frozen).
  int t = 0, p0 = 0, p1 = 0, lk = 0;
  int P0 = 4, P1 = 8;
  bit el = 0, er = 0;
  bit clr0 = 0, clr1 = 0, clr_lk = 0, rst_ev = 0;

  always #5 clk = ~clk;

  clk_ce_gen #(
    .NUM_CH      (2),
    .ACC_W       (8),
    .INC_DEFAULT ({8'd32, 8'd64}),
    .LOCK_CYCLES (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_sync  (cfg_sync),
    .ce        (ce),
    .clk_out   (clk_out),
    .locked    (locked),
    .rst_out_n (rst_out_n)
  );

  clk_ce_gen #(
    .NUM_CH      (3),
    .ACC_W       (8),
    .INC_DEFAULT ({8'd16, 8'd32, 8'd64}),
    .LOCK_CYCLES (16)
  ) dut3 (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_we    (cfg3_we),
    .cfg_ch    (cfg3_ch),
    .cfg_inc   (cfg3_inc),
    .cfg_sync  (cfg3_sync),
    .ce        (ce3),
    .clk_out   (clk_out3),
    .locked    (locked3),
    .rst_out_n (rst_out_n3)
  );

  function automatic bit exp_ce(int P, int p);
    if (P == 0 || p == 0) return 1'b0;
    return (p % P) == 0;
  endfunction

  function automatic bit exp_clk(int P, int p);
    if (P == 0) return 1'b0;
    return (p % P) >= (P / 2);
  endfunction

  // Advance one clock edge and update expectation counters; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_ev) begin
      t = 0; p0 = 0; p1 = 0; lk = 0; el = 0; er = 0;
    end else begin
      t++;
      p0 = clr0 ? 0 : p0 + 1;
      p1 = clr1 ? 0 : p1 + 1;
      lk = clr_lk ? 0 : lk + 1;
      er = el;
      el = (lk >= 16);
    end
    clr0 = 0; clr1 = 0; clr_lk = 0; rst_ev = 0;
  endtask

  // Free-running interval: both instances must follow their closed-form patterns.
  task automatic test_steady(input int cycles);
    logic [1:0] wce, wclk;
    logic [2:0] wce3, wclk3;
    for (int n = 0; n < cycles; n++) begin
      tick();
      wce   = {exp_ce(P1, p1), exp_ce(P0, p0)};
      wclk  = {exp_clk(P1, p1), exp_clk(P0, p0)};
      wce3  = {exp_ce(16, t), exp_ce(8, t), exp_ce(4, t)};
      wclk3 = {exp_clk(16, t), exp_clk(8, t), exp_clk(4, t)};
      total += 8;
      if (ce !== wce) begin bad++; $display("FAIL ce t=%0d got=%b want=%b", t, ce, wce); end
      if (clk_out !== wclk) begin bad++; $display("FAIL clk_out t=%0d got=%b want=%b", t, clk_out, wclk); end
      if (locked !== el) begin bad++; $display("FAIL locked t=%0d got=%b want=%b", t, locked, el); end
      if (rst_out_n !== er) begin bad++; $display("FAIL rst_out_n t=%0d got=%b want=%b", t, rst_out_n, er); end
      if (ce3 !== wce3) begin bad++; $display("FAIL ce3 t=%0d got=%b want=%b", t, ce3, wce3); end
      if (clk_out3 !== wclk3) begin bad++; $display("FAIL clk_out3 t=%0d got=%b want=%b", t, clk_out3, wclk3); end
      if (locked3 !== (t >= 16)) begin bad++; $display("FAIL locked3 t=%0d got=%b want=%b", t, locked3, (t >= 16)); end
      if (rst_out_n3 !== (t >= 17)) begin bad++; $display("FAIL rst_out_n3 t=%0d got=%b want=%b", t, rst_out_n3, (t >= 17)); end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rst_ev = 1; tick();
    rst_ev = 1; tick();
    total += 8;
    if (ce !== 2'b00) begin bad++; $display("FAIL reset_ce got=%b want=00", ce); end
    if (clk_out !== 2'b00) begin bad++; $display("FAIL reset_clk_out got=%b want=00", clk_out); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    if (rst_out_n !== 1'b0) begin bad++; $display("FAIL reset_rst_out_n got=%b want=0", rst_out_n); end
    if (ce3 !== 3'b000) begin bad++; $display("FAIL reset_ce3 got=%b want=000", ce3); end
    if (clk_out3 !== 3'b000) begin bad++; $display("FAIL reset_clk_out3 got=%b want=000", clk_out3); end
    if (locked3 !== 1'b0) begin bad++; $display("FAIL reset_locked3 got=%b want=0", locked3); end
    if (rst_out_n3 !== 1'b0) begin bad++; $display("FAIL reset_rst_out_n3 got=%b want=0", rst_out_n3); end
    resetn = 1'b1;
  endtask

  task automatic test_cfg_write();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd128;
    clr0 = 1; clr_lk = 1; P0 = 2;
    tick();
    cfg_we = 1'b0;
    total += 5;
    if (locked !== 1'b0) begin bad++; $display("FAIL wr_locked got=%b want=0", locked); end
    if (rst_out_n !== 1'b1) begin bad++; $display("FAIL wr_rst_out_n got=%b want=1", rst_out_n); end
    if (ce[0] !== 1'b0) begin bad++; $display("FAIL wr_ce0 got=%b want=0", ce[0]); end
    if (clk_out[0] !== 1'b0) begin bad++; $display("FAIL wr_clk0 got=%b want=0", clk_out[0]); end
    if (ce[1] !== exp_ce(P1, p1)) begin bad++; $display("FAIL wr_ce1 got=%b want=%b", ce[1], exp_ce(P1, p1)); end
    test_steady(20);
  endtask

  task automatic test_freeze();
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd0;
    clr1 = 1; clr_lk = 1; P1 = 0;
    tick();
    cfg_we = 1'b0;
    total += 3;
    if (ce[1] !== 1'b0) begin bad++; $display("FAIL frz_ce1 got=%b want=0", ce[1]); end
    if (clk_out[1] !== 1'b0) begin bad++; $display("FAIL frz_clk1 got=%b want=0", clk_out[1]); end
    if (locked !== 1'b0) begin bad++; $display("FAIL frz_locked got=%b want=0", locked); end
    test_steady(100);
  endtask

  task automatic test_invalid_ch();
    cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 8'd128;
    test_steady(1);
    cfg3_we = 1'b0;
    test_steady(16);
  endtask

  task automatic test_sync_terminal();
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd64;
    clr1 = 1; clr_lk = 1; P1 = 4;
    tick();
    cfg_we = 1'b0;
    test_steady(15);
    // Lock counter now at its terminal value: sync plus a ch0 write land on that edge.
    cfg_sync = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd128;
    clr0 = 1; clr1 = 1; clr_lk = 1;
    tick();
    cfg_sync = 1'b0; cfg_we = 1'b0;
    total += 3;
    if (locked !== 1'b0) begin bad++; $display("FAIL sync_locked got=%b want=0", locked); end
    if (ce !== 2'b00) begin bad++; $display("FAIL sync_ce got=%b want=00", ce); end
    if (clk_out !== 2'b00) begin bad++; $display("FAIL sync_clk_out got=%b want=00", clk_out); end
    test_steady(20);
  endtask

  task automatic test_mid_reset();
    resetn = 1'b0;
    rst_ev = 1;
    tick();
    resetn = 1'b1;
    P0 = 4; P1 = 8;
    total += 6;
    if (ce !== 2'b00) begin bad++; $display("FAIL mrst_ce got=%b want=00", ce); end
    if (clk_out !== 2'b00) begin bad++; $display("FAIL mrst_clk_out got=%b want=00", clk_out); end
    if (locked !== 1'b0) begin bad++; $display("FAIL mrst_locked got=%b want=0", locked); end
    if (rst_out_n !== 1'b0) begin bad++; $display("FAIL mrst_rst_out_n got=%b want=0", rst_out_n); end
    if (locked3 !== 1'b0) begin bad++; $display("FAIL mrst_locked3 got=%b want=0", locked3); end
    if (rst_out_n3 !== 1'b0) begin bad++; $display("FAIL mrst_rst_out_n3 got=%b want=0", rst_out_n3); end
    test_steady(24);
  endtask

  initial begin
    test_reset();
    test_steady(64);
    test_cfg_write();
    test_freeze();
    test_invalid_ch();
    test_sync_terminal();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
